// File: rtl/keypad_pkg.sv
// Shared types and helpers for the keypad matrix scanner.
//
// Contents:
//   scan_state_t    - debounce FSM states
//   frame_result_t  - classification of one complete scan frame
//   code_width()    - bit width needed to index n items (never below 1)
//   KEY_CODE_W      - key code width for the default 4x4 keypad
package keypad_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DEBOUNCE,
        ST_PRESSED,
        ST_RELEASE
    } scan_state_t;

    typedef enum logic [1:0] {
        FR_NONE,
        FR_KEY,
        FR_MULTI
    } frame_result_t;

    function automatic int code_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int KEY_CODE_W = code_width(16);

endpackage

// File: rtl/keypad_col_scan.sv
// Column scan timing for the keypad matrix.
//
// Holds each column active for SCAN_DIV clocks. Rows are sampled on the last
// dwell cycle, so the row lines have settled after the column switch.
//
// Ports:
//   clk, reset  - board clock, synchronous active-high reset
//   col_out     - one-hot active-low column drive (column 0 after reset)
//   col_idx     - index of the active column
//   sample      - high on the last dwell cycle of every column
//   frame_end   - high on the sample cycle of the last column
module keypad_col_scan
    import keypad_pkg::*;
#(
    parameter int N_COLS   = 4,
    parameter int SCAN_DIV = 50000,
    localparam int COL_W   = code_width(N_COLS)
) (
    input  logic              clk,
    input  logic              reset,
    output logic [N_COLS-1:0] col_out,
    output logic [COL_W-1:0]  col_idx,
    output logic              sample,
    output logic              frame_end
);
    localparam int DWELL_W = code_width(SCAN_DIV);

    logic [DWELL_W-1:0] dwell;

    assign sample    = (dwell == DWELL_W'(SCAN_DIV - 1));
    assign frame_end = sample && (col_idx == COL_W'(N_COLS - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            dwell   <= '0;
            col_idx <= '0;
        end else if (sample) begin
            dwell   <= '0;
            col_idx <= (col_idx == COL_W'(N_COLS - 1)) ? '0 : col_idx + 1'b1;
        end else begin
            dwell <= dwell + 1'b1;
        end
    end

    always_comb begin
        col_out          = '1;
        col_out[col_idx] = 1'b0;
    end

endmodule

// File: rtl/keypad_matrix_scanner.sv
// Keypad matrix scanner: drives active-low columns, samples active-low rows,
// debounces whole frames and reports one key code per accepted press.
//
// Optional feature macro: KEYPAD_AUTOREPEAT_EN (auto-repeat of key_valid while
// a key stays held; absent from the logic when undefined).
//
// Ports:
//   clk        - board clock
//   reset      - synchronous, active-high
//   row_in     - raw row returns, active-low, asynchronous to clk
//   col_out    - one-hot active-low column drive
//   key_code   - last accepted key, row*N_COLS + col
//   key_valid  - one-cycle pulse per accepted press (and per repeat)
//   key_held   - high while the accepted key is held
//   multi_err  - one-cycle pulse after a frame with two or more keys closed
//
// state       | meaning
// ------------+---------------------------------------------------------
// ST_IDLE     | no key accepted, waiting for a single-key frame
// ST_DEBOUNCE | candidate key seen in 'stable' consecutive frames
// ST_PRESSED  | key accepted, key_held high
// ST_RELEASE  | key apparently gone for 'rel' frames, key_held still high
module keypad_matrix_scanner
    import keypad_pkg::*;
#(
    parameter int N_COLS         = 4,
    parameter int N_ROWS         = 4,
    parameter int SCAN_DIV       = 50000,
    parameter int DEBOUNCE_SCANS = 4,
    parameter int REPEAT_DELAY   = 30,
    parameter int REPEAT_RATE    = 8,
    localparam int CODE_W        = code_width(N_ROWS * N_COLS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N_ROWS-1:0] row_in,
    output logic [N_COLS-1:0] col_out,
    output logic [CODE_W-1:0] key_code,
    output logic              key_valid,
    output logic              key_held,
    output logic              multi_err
);
    localparam int COL_W = code_width(N_COLS);
    localparam int ROW_W = code_width(N_ROWS);
    localparam int CNT_W = code_width(DEBOUNCE_SCANS + 1);

    // The two-flop synchroniser plus one settle cycle needs three dwell
    // cycles; a single-frame debounce would need acceptance straight from IDLE.
    if (SCAN_DIV < 3) begin : g_bad_scan_div
        $error("keypad_matrix_scanner: SCAN_DIV must be at least 3");
    end
    if (DEBOUNCE_SCANS < 2) begin : g_bad_debounce
        $error("keypad_matrix_scanner: DEBOUNCE_SCANS must be at least 2");
    end
    if (REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_bad_repeat
        $error("keypad_matrix_scanner: repeat parameters must be at least 1");
    end

    logic [COL_W-1:0] col_idx;
    logic             sample;
    logic             frame_end;

    keypad_col_scan #(
        .N_COLS   (N_COLS),
        .SCAN_DIV (SCAN_DIV)
    ) u_col_scan (
        .clk       (clk),
        .reset     (reset),
        .col_out   (col_out),
        .col_idx   (col_idx),
        .sample    (sample),
        .frame_end (frame_end)
    );

    logic [N_ROWS-1:0] row_meta;
    logic [N_ROWS-1:0] row_sync;

    always_ff @(posedge clk) begin
        if (reset) begin
            row_meta <= '1;
            row_sync <= '1;
        end else begin
            row_meta <= row_in;
            row_sync <= row_meta;
        end
    end

    // Closed keys in the active column: count (saturating at 2) and lowest row.
    logic [1:0]       col_hits;
    logic [ROW_W-1:0] col_first;

    always_comb begin
        col_hits  = 2'd0;
        col_first = '0;
        for (int r = 0; r < N_ROWS; r++) begin
            if (!row_sync[r]) begin
                if (col_hits == 2'd0) col_first = ROW_W'(r);
                if (col_hits != 2'd2) col_hits = col_hits + 2'd1;
            end
        end
    end

    // Frame accumulation; the totals include the column being sampled now so
    // the last column contributes on the frame_end cycle itself.
    logic [1:0]          acc_cnt;
    logic [CODE_W-1:0]   acc_code;
    logic [2:0]          sum_cnt;
    logic [1:0]          tot_cnt;
    logic [CODE_W-1:0]   col_code;
    logic [CODE_W-1:0]   frame_code;
    frame_result_t       frame_res;

    assign sum_cnt    = {1'b0, acc_cnt} + {1'b0, col_hits};
    assign tot_cnt    = (sum_cnt > 3'd2) ? 2'd2 : sum_cnt[1:0];
    assign col_code   = CODE_W'(int'(col_first) * N_COLS + int'(col_idx));
    assign frame_code = (acc_cnt != 2'd0) ? acc_code : col_code;

    always_comb begin
        frame_res = FR_NONE;
        if (tot_cnt == 2'd1)      frame_res = FR_KEY;
        else if (tot_cnt == 2'd2) frame_res = FR_MULTI;
    end

    always_ff @(posedge clk) begin
        if (reset || frame_end) begin
            acc_cnt  <= 2'd0;
            acc_code <= '0;
        end else if (sample) begin
            acc_cnt  <= tot_cnt;
            acc_code <= frame_code;
        end
    end

    scan_state_t       state, state_nx;
    logic [CODE_W-1:0] cand, cand_nx;
    logic [CNT_W-1:0]  stable, stable_nx;
    logic [CNT_W-1:0]  rel, rel_nx;
    logic [CODE_W-1:0] code_nx;
    logic              accept;
    logic              rpt_fire;

    always_comb begin
        state_nx  = state;
        cand_nx   = cand;
        stable_nx = stable;
        rel_nx    = rel;
        code_nx   = key_code;
        accept    = 1'b0;
        if (frame_end) begin
            case (state)
                ST_IDLE: begin
                    if (frame_res == FR_KEY) begin
                        state_nx  = ST_DEBOUNCE;
                        cand_nx   = frame_code;
                        stable_nx = CNT_W'(1);
                    end
                end
                ST_DEBOUNCE: begin
                    if (frame_res == FR_KEY && frame_code == cand) begin
                        if (stable == CNT_W'(DEBOUNCE_SCANS - 1)) begin
                            state_nx  = ST_PRESSED;
                            code_nx   = cand;
                            accept    = 1'b1;
                            stable_nx = '0;
                        end else begin
                            stable_nx = stable + 1'b1;
                        end
                    end else if (frame_res == FR_KEY) begin
                        cand_nx   = frame_code;
                        stable_nx = CNT_W'(1);
                    end else begin
                        state_nx  = ST_IDLE;
                        stable_nx = '0;
                    end
                end
                ST_PRESSED: begin
                    if (frame_res == FR_NONE ||
                        (frame_res == FR_KEY && frame_code != cand)) begin
                        state_nx = ST_RELEASE;
                        rel_nx   = CNT_W'(1);
                    end
                end
                ST_RELEASE: begin
                    // A multi-key frame neither confirms nor extends the release.
                    if (frame_res == FR_KEY && frame_code == cand) begin
                        state_nx = ST_PRESSED;
                        rel_nx   = '0;
                    end else if (frame_res != FR_MULTI) begin
                        if (rel == CNT_W'(DEBOUNCE_SCANS - 1)) begin
                            state_nx = ST_IDLE;
                            rel_nx   = '0;
                        end else begin
                            rel_nx = rel + 1'b1;
                        end
                    end
                end
                default: state_nx = ST_IDLE;
            endcase
        end
    end

`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RPT_W   = code_width(RPT_MAX + 1);

    logic [RPT_W-1:0] rpt_cnt, rpt_cnt_nx;
    logic             rpt_armed, rpt_armed_nx;  // first repeat already issued
    logic [RPT_W-1:0] rpt_target;

    assign rpt_target = rpt_armed ? RPT_W'(REPEAT_RATE) : RPT_W'(REPEAT_DELAY);

    always_comb begin
        rpt_cnt_nx   = rpt_cnt;
        rpt_armed_nx = rpt_armed;
        rpt_fire     = 1'b0;
        if (state_nx == ST_IDLE || state_nx == ST_DEBOUNCE) begin
            rpt_cnt_nx   = '0;
            rpt_armed_nx = 1'b0;
        end else if (frame_end && state == ST_PRESSED && state_nx == ST_PRESSED) begin
            if (rpt_cnt + 1'b1 == rpt_target) begin
                rpt_fire     = 1'b1;
                rpt_cnt_nx   = '0;
                rpt_armed_nx = 1'b1;
            end else begin
                rpt_cnt_nx = rpt_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rpt_cnt   <= '0;
            rpt_armed <= 1'b0;
        end else begin
            rpt_cnt   <= rpt_cnt_nx;
            rpt_armed <= rpt_armed_nx;
        end
    end
`else
    assign rpt_fire = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            cand      <= '0;
            stable    <= '0;
            rel       <= '0;
            key_code  <= '0;
            key_valid <= 1'b0;
            multi_err <= 1'b0;
        end else begin
            state     <= state_nx;
            cand      <= cand_nx;
            stable    <= stable_nx;
            rel       <= rel_nx;
            key_code  <= code_nx;
            key_valid <= accept | rpt_fire;
            multi_err <= frame_end && (frame_res == FR_MULTI);
        end
    end

    assign key_held = (state == ST_PRESSED) || (state == ST_RELEASE);

endmodule

// File: tb/tb_keypad_matrix_scanner.sv
`timescale 1ns/1ps
module tb_keypad_matrix_scanner;
    localparam int N_COLS    = 4;
    localparam int N_ROWS    = 4;
    localparam int SCAN_DIV  = 4;
    localparam int DEB       = 3;
    localparam int RPT_DELAY = 2;
    localparam int RPT_RATE  = 1;
    localparam int FRAME     = N_COLS * SCAN_DIV;
    localparam int NKEYS     = N_COLS * N_ROWS;

    logic              clk   = 1'b0;
    logic              reset = 1'b1;
    logic [N_ROWS-1:0] row_in;
    logic [N_COLS-1:0] col_out;
    logic [3:0]        key_code;
    logic              key_valid;
    logic              key_held;
    logic              multi_err;
    logic [NKEYS-1:0]  keys = '0;

    int n_checks = 0;
    int n_err    = 0;
    int kv_seen  = 0;
    int me_seen  = 0;

    always #5 clk = ~clk;

    keypad_matrix_scanner #(
        .N_COLS         (N_COLS),
        .N_ROWS         (N_ROWS),
        .SCAN_DIV       (SCAN_DIV),
        .DEBOUNCE_SCANS (DEB),
        .REPEAT_DELAY   (RPT_DELAY),
        .REPEAT_RATE    (RPT_RATE)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .row_in    (row_in),
        .col_out   (col_out),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_held  (key_held),
        .multi_err (multi_err)
    );

    // Physical keypad: a closed key pulls its row low while its column is driven low.
    always_comb begin
        row_in = '1;
        for (int r = 0; r < N_ROWS; r++)
            for (int c = 0; c < N_COLS; c++)
                if (keys[r*N_COLS+c] && col_out[c] == 1'b0) row_in[r] = 1'b0;
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Frame classification straight from the key set: column-major scan order.
    function automatic void frame_eval(input logic [NKEYS-1:0] k, output int cnt, output int code);
        cnt  = 0;
        code = 0;
        for (int c = 0; c < N_COLS; c++)
            for (int r = 0; r < N_ROWS; r++)
                if (k[r*N_COLS+c]) begin
                    if (cnt == 0) code = r*N_COLS + c;
                    cnt++;
                end
    endfunction

    // Behavioural reference: cycle count since reset, debounce run lengths.
    bit m_live = 0;
    int m_k, m_run, m_rcode, m_rel, m_hcode, m_rcnt;
    bit m_held, m_rstarted;
    int e_code, e_col;
    bit e_valid, e_multi;

    task automatic rpt_tick();
`ifdef KEYPAD_AUTOREPEAT_EN
        m_rcnt++;
        if (m_rcnt == (m_rstarted ? RPT_RATE : RPT_DELAY)) begin
            e_valid    = 1'b1;
            m_rcnt     = 0;
            m_rstarted = 1'b1;
        end
`endif
    endtask

    always @(posedge clk) begin
        int cnt, code;
        if (reset) begin
            m_live = 1'b1; m_k = 0; m_run = 0; m_rcode = 0; m_rel = 0; m_hcode = 0;
            m_rcnt = 0; m_held = 1'b0; m_rstarted = 1'b0;
            e_code = 0; e_col = 0; e_valid = 1'b0; e_multi = 1'b0;
        end else if (m_live) begin
            e_valid = 1'b0;
            e_multi = 1'b0;
            if (m_k % FRAME == FRAME - 1) begin
                frame_eval(keys, cnt, code);
                e_multi = (cnt >= 2);
                if (!m_held) begin
                    if (cnt == 1) begin
                        if (m_run > 0 && code == m_rcode) m_run++;
                        else begin m_run = 1; m_rcode = code; end
                        if (m_run == DEB) begin
                            m_held = 1'b1; m_hcode = code; m_run = 0; m_rel = 0;
                            m_rcnt = 0; m_rstarted = 1'b0;
                            e_valid = 1'b1; e_code = code;
                        end
                    end else begin
                        m_run = 0;
                    end
                end else if (cnt == 1 && code == m_hcode) begin
                    if (m_rel == 0) rpt_tick();
                    m_rel = 0;
                end else if (cnt >= 2) begin
                    if (m_rel == 0) rpt_tick();
                end else begin
                    m_rel++;
                    if (m_rel == DEB) begin
                        m_held = 1'b0; m_rel = 0; m_rcnt = 0; m_rstarted = 1'b0;
                    end
                end
            end
            m_k++;
            e_col = (m_k / SCAN_DIV) % N_COLS;
        end
    end

    always @(negedge clk) begin
        logic [N_COLS-1:0] ec;
        if (m_live) begin
            ec        = '1;
            ec[e_col] = 1'b0;
            check("col_out", int'(col_out), int'(ec));
            check("key_code", int'(key_code), e_code);
            check("key_valid", int'(key_valid), int'(e_valid));
            check("key_held", int'(key_held), int'(m_held));
            check("multi_err", int'(multi_err), int'(e_multi));
            if (key_valid === 1'b1) kv_seen++;
            if (multi_err === 1'b1) me_seen++;
        end
    end

    task automatic run_frames(input logic [NKEYS-1:0] k, input int n);
        keys = k;
        repeat (n * FRAME) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    function automatic logic [NKEYS-1:0] key_bit(input int code);
        logic [NKEYS-1:0] v;
        v       = '0;
        v[code] = 1'b1;
        return v;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N_COLS-1:0] col_pat [4];
        logic [NKEYS-1:0]  cur;
        int cnt, code, kv0, me0, roll, sel, a, b;

        col_pat[0] = 4'b1110; col_pat[1] = 4'b1101;
        col_pat[2] = 4'b1011; col_pat[3] = 4'b0111;

        // Pin the frame classifier with hand-computed cases.
        frame_eval(key_bit(6), cnt, code);
        check("model_single_cnt", cnt, 1);
        check("model_single_code", code, 6);
        frame_eval(key_bit(1) | key_bit(4), cnt, code);
        check("model_order_col_first", code, 4);
        frame_eval(key_bit(14) | key_bit(3) | key_bit(9), cnt, code);
        check("model_multi_cnt", cnt, 3);
        check("model_order_code", code, 9);

        // 1: reset and idle scan.
        do_reset();
        check("rst_col_out", int'(col_out), 4'b1110);
        check("rst_key_code", int'(key_code), 0);
        for (int i = 0; i < 4 * FRAME; i++) begin
            @(negedge clk);
            if (i % SCAN_DIV == 0)
                check("idle_col_pattern", int'(col_out), int'(col_pat[(i / SCAN_DIV) % N_COLS]));
        end
        @(posedge clk);
        #1;
        check("idle_no_valid", kv_seen, 0);
        check("idle_no_multi", me_seen, 0);

        // 2: hold key 6 (row1, col2) for 6 frames.
        kv0 = kv_seen;
        run_frames(key_bit(6), 6);
        check("press_valid_count", kv_seen - kv0, 1);
        check("press_code", int'(key_code), 6);
        check("press_held", int'(key_held), 1);

        // 3: release for 3 frames.
        kv0 = kv_seen;
        run_frames('0, 3);
        check("release_held", int'(key_held), 0);
        check("release_no_valid", kv_seen - kv0, 0);

        // 4: interrupted debounce, then three unbroken frames.
        kv0 = kv_seen;
        run_frames(key_bit(6), 2);
        run_frames('0, 1);
        run_frames(key_bit(6), 2);
        check("bounce_no_valid", kv_seen - kv0, 0);
        check("bounce_valid_now", int'(key_valid), 0);
        run_frames(key_bit(6), 1);
        check("unbroken_valid", int'(key_valid), 1);
        run_frames('0, 3);

        // 5: two keys in one frame, then reset in the middle of DEBOUNCE.
        kv0 = kv_seen;
        me0 = me_seen;
        run_frames(key_bit(0) | key_bit(5), 3);
        run_frames(key_bit(6), 2);
        check("multi_pulses", me_seen - me0, 3);
        check("multi_no_valid", kv_seen - kv0, 0);
        keys = key_bit(6);
        repeat (5) @(posedge clk);
        #1;
        do_reset();
        check("midrst_col_out", int'(col_out), 4'b1110);
        check("midrst_valid", int'(key_valid), 0);
        check("midrst_held", int'(key_held), 0);
        check("midrst_multi", int'(multi_err), 0);
        kv0 = kv_seen;
        run_frames('0, 2);
        check("midrst_no_late_valid", kv_seen - kv0, 0);

        // 6: long hold of key 15 (auto-repeat when enabled).
        kv0 = kv_seen;
        run_frames(key_bit(15), 3 + 8);
        check("hold_code", int'(key_code), 15);
`ifdef KEYPAD_AUTOREPEAT_EN
        check("repeat_count", kv_seen - kv0, 7);
        check("repeat_pulse_now", int'(key_valid), 1);
`else
        check("single_valid_count", kv_seen - kv0, 1);
        check("no_repeat_now", int'(key_valid), 0);
`endif
        run_frames('0, 3);

        // Randomised frames with persistence and occasional mid-frame resets.
        cur = '0;
        for (int f = 0; f < 240; f++) begin
            roll = $urandom_range(99);
            if (roll < 4) begin
                repeat ($urandom_range(15, 1)) @(posedge clk);
                #1;
                do_reset();
            end
            roll = $urandom_range(99);
            if (roll >= 70) begin
                sel = $urandom_range(99);
                cur = '0;
                if (sel >= 20 && sel < 80) begin
                    cur[$urandom_range(NKEYS - 1)] = 1'b1;
                end else if (sel >= 80) begin
                    a = $urandom_range(NKEYS - 1);
                    b = (a + $urandom_range(NKEYS - 1, 1)) % NKEYS;
                    cur[a] = 1'b1;
                    cur[b] = 1'b1;
                end
            end
            run_frames(cur, 1);
        end
        run_frames('0, 4);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
